// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, instruction field layout, legality check.
// No timing; no flow control.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1111;

    localparam int OP_LSB     = 28;
    localparam int IMMSEL_BIT = 27;
    localparam int RD_LSB     = 24;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 18;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR: is_legal_op = 1'b1;
            default:                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// NREG x DW register file, two async read ports with write bypass, r0 reads zero.
// Read: combinational; write: takes effect at the next clk edge.
// No backpressure; a write is always accepted.
module regfile_2r1w #(
    parameter int NREG = 8,
    parameter int DW   = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle writeback is forwarded so the reader never sees a stale value.
    always_comb begin
        rdata_a = mem[raddr_a];
        if (raddr_a == '0)                rdata_a = '0;
        else if (we && waddr == raddr_a)  rdata_a = wdata;
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (raddr_b == '0)                rdata_b = '0;
        else if (we && waddr == raddr_b)  rdata_b = wdata;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode, scoreboard-checked operand read and issue register in front of the ALU.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops when the output slot is held or a source is pending.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 32,
    parameter int CNTW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic                     wb_en,
    input  logic [$clog2(NREG)-1:0]  wb_addr,
    input  logic [DW-1:0]            wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            A,
    output logic [DW-1:0]            B,
    output logic [3:0]               ALU_op,
    output logic [$clog2(NREG)-1:0]  rd_out,
    output logic                     illegal,
    output logic [CNTW-1:0]          illegal_cnt
);

    localparam int AW = $clog2(NREG);

    logic [3:0]       op;
    logic             imm_sel;
    logic [AW-1:0]    rd, rs, rt;
    logic [IMM_W-1:0] imm;
    logic             unused_bits;

    assign op          = instr[OP_LSB +: 4];
    assign imm_sel     = instr[IMMSEL_BIT];
    assign rd          = instr[RD_LSB +: AW];
    assign rs          = instr[RS_LSB +: AW];
    assign rt          = instr[RT_LSB +: AW];
    assign imm         = instr[IMM_LSB +: IMM_W];
    assign unused_bits = ^instr[17:16];

    logic [DW-1:0] rdata_a, rdata_b;

    regfile_2r1w #(.NREG(NREG), .DW(DW), .AW(AW)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rdata_a),
        .raddr_b (rt),
        .rdata_b (rdata_b)
    );

    logic [NREG-1:0] pend;
    logic            free, hazard, legal, accept, legal_acc, illegal_acc;
    logic            wb_hits_rs, wb_hits_rt;

    assign wb_hits_rs = wb_en && (wb_addr == rs);
    assign wb_hits_rt = wb_en && (wb_addr == rt);

    // A writeback landing this cycle resolves the dependency, so it does not stall.
    assign hazard = (rs != '0 && pend[rs] && !wb_hits_rs) ||
                    (!imm_sel && rt != '0 && pend[rt] && !wb_hits_rt);

    assign free        = !out_valid || out_ready;
    assign legal       = is_legal_op(op);
    assign in_ready    = free && (!legal || !hazard);
    assign accept      = in_valid && in_ready;
    assign legal_acc   = accept && legal;
    assign illegal_acc = accept && !legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            A         <= '0;
            B         <= '0;
            ALU_op    <= '0;
            rd_out    <= '0;
        end else begin
            if (legal_acc) begin
                out_valid <= 1'b1;
                A         <= rdata_a;
                B         <= imm_sel ? {{(DW-IMM_W){1'b0}}, imm} : rdata_b;
                ALU_op    <= op;
                rd_out    <= rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Set after clear so a new issue to rd wins over a same-edge writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            logic [NREG-1:0] nxt;
            nxt = pend;
            if (wb_en && wb_addr != '0) nxt[wb_addr] = 1'b0;
            if (legal_acc && rd != '0)  nxt[rd] = 1'b1;
            pend <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            illegal <= illegal_acc;
            if (illegal_acc && illegal_cnt != {CNTW{1'b1}})
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; checks at negedge, drives 1 ns after posedge.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A, B;
    logic [3:0]  ALU_op;
    logic [2:0]  rd_out;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.NREG(8), .DW(32), .CNTW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A           (A),
        .B           (B),
        .ALU_op      (ALU_op),
        .rd_out      (rd_out),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic isel,
                                       input logic [2:0] rd, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [15:0] imm);
        mk = {op, isel, rd, rs, rt, 2'b00, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_op", ALU_op, 0);
        check("rst_rd", rd_out, 0);
        check("rst_illegal", illegal, 0);
        check("rst_cnt", illegal_cnt, 0);
        step(); step();
        rst_n = 1'b1;
        samp();
        check("idle_in_ready", in_ready, 1);

        // Immediate path: r1 <- r0 + 0x1234
        step();
        instr = mk(4'b0000, 1'b1, 3'd1, 3'd0, 3'd0, 16'h1234); in_valid = 1'b1;
        samp();
        check("imm_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        instr = mk(4'b0000, 1'b1, 3'd7, 3'd1, 3'd0, 16'h0);
        samp();
        check("imm_out_valid", out_valid, 1);
        check("imm_A", A, 32'h0);
        check("imm_B", B, 32'h0000_1234);
        check("imm_op", ALU_op, 4'b0000);
        check("imm_rd", rd_out, 1);
        check("pend1_blocks", in_ready, 0);
        step();
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'h1234;
        samp();
        check("pend1_wb_bypass", in_ready, 1);
        step();
        wb_en = 1'b0;
        samp();
        check("pend1_cleared", in_ready, 1);
        check("drain_out_valid", out_valid, 0);

        // RAW stall and forward: r2 <- r0+5 ; r3 <- r2+r2
        step();
        instr = mk(4'b0000, 1'b1, 3'd2, 3'd0, 3'd0, 16'd5); in_valid = 1'b1;
        step();
        instr = mk(4'b0000, 1'b0, 3'd3, 3'd2, 3'd2, 16'd0);
        samp();
        check("raw_stall0", in_ready, 0);
        check("raw_first_B", B, 5);
        check("raw_first_rd", rd_out, 2);
        step();
        samp();
        check("raw_stall1", in_ready, 0);
        check("raw_no_issue", out_valid, 0);
        step();
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'd5;
        samp();
        check("raw_wb_ready", in_ready, 1);
        step();
        wb_en = 1'b0;
        instr = mk(4'b0001, 1'b1, 3'd4, 3'd2, 3'd0, 16'd7);
        samp();
        check("raw_valid", out_valid, 1);
        check("raw_A", A, 5);
        check("raw_B", B, 5);
        check("raw_rd", rd_out, 3);

        // Backpressure: hold r3 op for 3 cycles while r4 <- r2 - 7 waits
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_A", A, 5);
            check("bp_B", B, 5);
            check("bp_rd", rd_out, 3);
            step();
        end
        out_ready = 1'b1;
        samp();
        check("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'd10;
        samp();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_A", A, 5);
        check("bp_next_B", B, 7);
        check("bp_next_op", ALU_op, 4'b0001);
        check("bp_next_rd", rd_out, 4);
        step();
        wb_addr = 3'd4; wb_data = 32'hFFFF_FFFE;
        step();
        wb_en = 1'b0;

        // Illegal opcode 0010 with rd=5
        instr = mk(4'b0010, 1'b0, 3'd5, 3'd0, 3'd0, 16'd0); in_valid = 1'b1;
        samp();
        check("ill_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        instr = mk(4'b0000, 1'b0, 3'd0, 3'd5, 3'd5, 16'd0);
        samp();
        check("ill_pulse", illegal, 1);
        check("ill_cnt1", illegal_cnt, 1);
        check("ill_no_valid", out_valid, 0);
        check("ill_no_pend5", in_ready, 1);
        step();
        samp();
        check("ill_pulse_end", illegal, 0);
        step();
        instr = mk(4'b0010, 1'b0, 3'd5, 3'd0, 3'd0, 16'd0); in_valid = 1'b1;
        for (int i = 0; i < 299; i++) step();
        in_valid = 1'b0;
        samp();
        check("ill_sat_cnt", illegal_cnt, 255);
        check("ill_last_pulse", illegal, 1);

        // r0 rules: write to r0 ignored, rd=0 sets no pending bit
        step();
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 32'hFFFF_FFFF;
        instr = mk(4'b0000, 1'b0, 3'd0, 3'd0, 3'd0, 16'd0); in_valid = 1'b1;
        samp();
        check("r0_in_ready", in_ready, 1);
        step();
        wb_en = 1'b0;
        instr = mk(4'b0111, 1'b0, 3'd0, 3'd2, 3'd3, 16'd0);
        samp();
        check("r0_A", A, 0);
        check("r0_B", B, 0);
        check("r0_no_pend", in_ready, 1);
        step();
        in_valid = 1'b0;
        samp();
        check("rf_A_r2", A, 5);
        check("rf_B_r3", B, 10);
        check("rf_op_or", ALU_op, 4'b0111);

        // Reset mid-op with output held
        step();
        out_ready = 1'b0;
        instr = mk(4'b0000, 1'b1, 3'd6, 3'd0, 3'd0, 16'd9); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        samp();
        check("mid_valid", out_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_A", A, 0);
        check("mid_rst_B", B, 0);
        check("mid_rst_rd", rd_out, 0);
        check("mid_rst_cnt", illegal_cnt, 0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        instr = mk(4'b0000, 1'b1, 3'd1, 3'd6, 3'd0, 16'd0);
        samp();
        check("mid_rst_pend6", in_ready, 1);
        step();
        instr = mk(4'b0000, 1'b0, 3'd1, 3'd2, 3'd3, 16'd0); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        samp();
        check("mid_rst_r2", A, 0);
        check("mid_rst_r3", B, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Issue/operand stage directly upstream of the 32-bit ALU. It decodes a 32-bit instruction word and reads two operands from an internal 8x32 register file. It holds any instruction whose source registers still await ALU writeback (scoreboard), then presents A, B and ALU_op to the ALU through a valid/ready output register. ALU results return on a writeback port that updates the register file and clears the scoreboard.

Parameters:
NREG, 8, number of architectural registers (r0 hardwired to zero); address width = log2(NREG)
DW, 32, datapath width (matches ALU A/B/Result)
CNTW, 8, width of saturating illegal-op counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction word valid
in_ready  output  1  stage accepts instruction this cycle
instr  input  32  [31:28] ALU_op, [27] imm_sel, [26:24] rd, [23:21] rs, [20:18] rt, [15:0] imm
wb_en  input  1  writeback strobe from ALU result path
wb_addr  input  3  writeback destination register
wb_data  input  DW  writeback value (ALU Result)
out_valid  output  1  A/B/ALU_op/rd_out valid toward ALU
out_ready  input  1  downstream consumes current output
A  output  DW  operand A = R[rs]
B  output  DW  operand B = imm_sel ? zero-extended imm : R[rt]
ALU_op  output  4  passed-through opcode
rd_out  output  3  destination tag travelling with the op
illegal  output  1  one-cycle pulse when an illegal opcode is dropped
illegal_cnt  output  CNTW  saturating count of dropped illegal instructions

Behaviour:
- Reset (async, rst_n=0): all registers R0..R7=0, scoreboard=0, out_valid=0, A=B=0, ALU_op=0, rd_out=0, illegal=0, illegal_cnt=0. Deassertion takes effect at the next clk edge. An in-flight output is discarded.
- Legal ALU_op: 0000 add, 0001 sub, 0011 and, 0111 or, 1111 shr. Any other value is illegal.
- Output slot free: free = !out_valid || out_ready.
- Hazard: (rs!=0 && pend[rs] && !(wb_en && wb_addr==rs)) || (!imm_sel && rt!=0 && pend[rt] && !(wb_en && wb_addr==rt)).
- in_ready = free && !hazard. Illegal instructions ignore the hazard term, so in_ready = free for them.
- Accept = in_valid && in_ready. A legal accept loads A/B/ALU_op/rd_out and sets out_valid=1 at the next edge: 1-cycle latency.
- If out_ready=1 and no accept occurs, out_valid clears. Outputs hold stable while out_valid && !out_ready.
- Illegal accept: the instruction is consumed, nothing is issued, and out_valid follows the free rule. illegal pulses high for 1 cycle. illegal_cnt increments and saturates at 2^CNTW-1.
- Operand read: R0 always reads 0. If wb_en && wb_addr==src && wb_addr!=0 in the same cycle, wb_data is forwarded (write-before-read bypass).
- Writeback: on wb_en with wb_addr!=0, R[wb_addr]<=wb_data and pend[wb_addr]<=0. Writes to r0 are ignored.
- Scoreboard: a legal accept with rd!=0 sets pend[rd]. If the same edge sees a wb clear for that address, set wins. A second issue to an already-pending rd is allowed (WAW is in-order, since the ALU is in-order and single-stage).
- Output register is a simple one-entry register; no skid buffer. Throughput is 1/cycle when out_ready=1 and there are no hazards.
- in_valid dropping while in_ready=0 is legal. The stage keeps no copy of instr.

Decomposition:
- Shared package alu_pkg: ALU_op encodings (OP_ADD=4'b0000, OP_SUB=4'b0001, OP_AND=4'b0011, OP_OR=4'b0111, OP_SHR=4'b1111), instr field bit positions, and function is_legal_op. The ALU and this stage both import it.
- Sub-module regfile_2r1w: NREG x DW, two async read ports with write bypass, one sync write port, r0 read as zero, async active-low reset. The scoreboard, handshake and decode stay in the top level.

Test Plan:
- Reset mid-op: issue add, assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0, all outputs 0, pend all 0 immediately, before any clock edge.
- Immediate path: instr op=0000, imm_sel=1, rd=1, rs=0, imm=0x1234, out_ready=1 -> next cycle A=0, B=0x00001234, ALU_op=0000, rd_out=1, pend[1]=1.
- RAW stall and forward: issue rd=2 ← r0+5, then r3 ← r2+r2 -> in_ready=0 until wb_en=1, wb_addr=2, wb_data=5. In that same cycle in_ready=1 and the issued op has A=B=5.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. On out_ready=1, the next instruction is loaded at the following edge.
- Illegal op: ALU_op=0010 -> illegal pulses 1 cycle, illegal_cnt 0→1, out_valid stays 0, pend unchanged. Issuing 300 illegals leaves illegal_cnt=255.
- r0 rules: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, then read rs=0 -> A=0. Issue with rd=0 -> no pend bit set.
